// File: rtl/dcache_if.sv
// dcache_if: core data port and main-memory beat port of the data cache.
//   Core side    : en_i, we_i, addr_i, wdata_i -> rdata_o, hit_o
//   Memory side  : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o -> mem_rdata_i, mem_ready_i
// The _i/_o suffixes are taken from the cache's point of view.
// The slave modport is used by the cache. The master modport is used by
// whatever drives the core requests and answers the memory beats.
interface dcache_if;
  logic        en_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        hit_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  modport slave (
    input  en_i, we_i, addr_i, wdata_i, mem_rdata_i, mem_ready_i,
    output rdata_o, hit_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output en_i, we_i, addr_i, wdata_i, mem_rdata_i, mem_ready_i,
    input  rdata_o, hit_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache.
//   clk_i : clock, all state changes on the rising edge
//   rst_i : asynchronous active-high reset (invalidates every line, FSM to IDLE)
//   bus   : dcache_if.slave (core request/response plus memory beat port)
// Hits complete in the request cycle. A miss first writes back a dirty victim
// (WRITEBACK), then refills the line one word per accepted beat (ALLOCATE).
// After the refill it returns to IDLE, where the held request hits.
module dcache #(
  parameter int SET_BITS    = 4,
  parameter int OFFSET_BITS = 2
) (
  input logic     clk_i,
  input logic     rst_i,
  dcache_if.slave bus
);
  localparam int LINES    = 1 << SET_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_BITS = 32 - SET_BITS - OFFSET_BITS - 2;
  localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t                  state_reg, state_next;
  logic [OFFSET_BITS-1:0]  beat_reg, beat_next;
  logic [TAG_BITS-1:0]     miss_tag_reg;
  logic [SET_BITS-1:0]     miss_index_reg;
  logic [LINES-1:0]        valid_reg, valid_next, dirty_reg, dirty_next;

  logic [TAG_BITS-1:0]     tag_mem  [LINES];
  logic [31:0]             data_mem [LINES*WORDS];

  logic [OFFSET_BITS-1:0]  offset;
  logic [SET_BITS-1:0]     index;
  logic [TAG_BITS-1:0]     tag;
  logic                    match;
  logic                    store_hit, miss_start, fill_we, wb_done, fill_done;
  logic                    unused_ok;

  assign offset    = bus.addr_i[OFFSET_BITS+1:2];
  assign index     = bus.addr_i[SET_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
  assign tag       = bus.addr_i[31:SET_BITS+OFFSET_BITS+2];
  assign match     = valid_reg[index] && (tag_mem[index] == tag);
  assign unused_ok = &{1'b0, bus.addr_i[1:0]};

  // Load data is read asynchronously from the indexed word.
  assign bus.rdata_o = data_mem[{index, offset}];

  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    bus.hit_o       = ~bus.en_i;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = 32'h0;
    bus.mem_wdata_o = 32'h0;
    store_hit       = 1'b0;
    miss_start      = 1'b0;
    fill_we         = 1'b0;
    wb_done         = 1'b0;
    fill_done       = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.hit_o = ~bus.en_i | match;
        store_hit = bus.en_i & bus.we_i & match;
        if (bus.en_i && !match) begin
          miss_start = 1'b1;
          beat_next  = '0;
          // dirty is only ever set on a valid line, but gate it anyway.
          state_next = (valid_reg[index] && dirty_reg[index]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        // The victim tag is still in tag_mem until the refill completes.
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = {tag_mem[miss_index_reg], miss_index_reg, beat_reg, 2'b00};
        bus.mem_wdata_o = data_mem[{miss_index_reg, beat_reg}];
        if (bus.mem_ready_i) begin
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT) begin
            wb_done    = 1'b1;
            state_next = ALLOCATE;
          end
        end
      end
      ALLOCATE: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = {miss_tag_reg, miss_index_reg, beat_reg, 2'b00};
        if (bus.mem_ready_i) begin
          fill_we   = 1'b1;
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT) begin
            fill_done  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-line valid/dirty next-state.
  // The line under miss uses the latched index, so it is unaffected if the
  // core drops en_i or changes the address mid-fill.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      localparam logic [SET_BITS-1:0] LINE_ID = SET_BITS'(gi);
      assign valid_next[gi] = (fill_done && miss_index_reg == LINE_ID) ? 1'b1 : valid_reg[gi];
      assign dirty_next[gi] = (store_hit && index == LINE_ID) ? 1'b1 :
                              ((wb_done || fill_done) && miss_index_reg == LINE_ID) ? 1'b0 :
                              dirty_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      miss_tag_reg   <= '0;
      miss_index_reg <= '0;
      valid_reg      <= '0;
      dirty_reg      <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      valid_reg <= valid_next;
      dirty_reg <= dirty_next;
      if (miss_start) begin
        miss_tag_reg   <= tag;
        miss_index_reg <= index;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  // A store hit and a refill beat never coincide, because they happen in
  // different states.
  always_ff @(posedge clk_i) begin
    if (store_hit)
      data_mem[{index, offset}] <= bus.wdata_i;
    else if (fill_we)
      data_mem[{miss_index_reg, beat_reg}] <= bus.mem_rdata_i;
    if (fill_done)
      tag_mem[miss_index_reg] <= miss_tag_reg;
  end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed test of dcache with a behavioural word memory.
module tb_dcache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus();

  dcache #(.SET_BITS(4), .OFFSET_BITS(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  logic [31:0] mem_model [0:1023];
  assign bus.mem_rdata_i = mem_model[bus.mem_addr_o[11:2]];

  int n_cmp = 0;
  int n_bad = 0;
  int pc = 0;
  int last_beat_pc = 0;
  int stab_err = 0;
  int rcnt = 0;
  bit ready_mode = 1'b0;

  logic        log_we[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  // Ready is updated on the falling edge: always 1, or once every third cycle.
  always @(negedge clk) begin
    rcnt++;
    bus.mem_ready_i = ready_mode ? (rcnt % 3 == 0) : 1'b1;
  end

  // Beat monitor: samples just before each rising edge.
  // It logs the beats that are accepted and checks that a held request does
  // not change its address while it waits for ready.
  logic        holding = 1'b0;
  logic [31:0] hold_addr = 32'h0;
  always begin
    @(negedge clk);
    #4;
    pc++;
    if (bus.mem_req_o) begin
      if (holding && bus.mem_addr_o !== hold_addr) stab_err++;
      if (bus.mem_ready_i) begin
        log_we.push_back(bus.mem_we_o);
        log_addr.push_back(bus.mem_addr_o);
        log_data.push_back(bus.mem_wdata_o);
        if (bus.mem_we_o) mem_model[bus.mem_addr_o[11:2]] = bus.mem_wdata_o;
        last_beat_pc = pc;
        holding = 1'b0;
      end else begin
        holding   = 1'b1;
        hold_addr = bus.mem_addr_o;
      end
    end else begin
      holding = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  // Issue one request. Returns in the cycle where hit_o is seen high, or after
  // the cycle budget runs out.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int cycles);
    @(negedge clk);
    bus.en_i    = 1'b1;
    bus.we_i    = w;
    bus.addr_i  = a;
    bus.wdata_i = d;
    #1;
    cycles = 1;
    while (!bus.hit_o && cycles < 40) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    $display("txn %s addr=%h wdata=%h cycles=%0d hit=%b rdata=%h",
             w ? "store" : "load ", a, d, cycles, bus.hit_o, bus.rdata_o);
  endtask

  task automatic check_beats(input string tag, input int first, input logic w,
                             input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      if (first + i < log_addr.size()) begin
        check_eq({tag, " we"}, {31'h0, log_we[first+i]}, {31'h0, w});
        check_eq({tag, " addr"}, log_addr[first+i], base + 32'(4 * i));
      end else begin
        check_eq({tag, " missing beat"}, 32'(first + i), 32'(log_addr.size()));
      end
    end
  endtask

  int cyc;

  initial begin
    bus.en_i    = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = 32'h0;
    bus.wdata_i = 32'h0;
    bus.mem_ready_i = 1'b1;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
    mem_model[16]  = 32'h11; mem_model[17]  = 32'h22; mem_model[18]  = 32'h33; mem_model[19]  = 32'h44;
    mem_model[272] = 32'h55; mem_model[273] = 32'h66; mem_model[274] = 32'h77; mem_model[275] = 32'h88;
    mem_model[32]  = 32'hA0; mem_model[33]  = 32'hA1; mem_model[34]  = 32'hA2; mem_model[35]  = 32'hA3;
    mem_model[48]  = 32'h99; mem_model[49]  = 32'h9A; mem_model[50]  = 32'h9B; mem_model[51]  = 32'h9C;

    // Reset state: outputs while reset is held.
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset hit", {31'h0, bus.hit_o}, 32'h1);
    check_eq("reset req", {31'h0, bus.mem_req_o}, 32'h0);
    check_eq("reset we", {31'h0, bus.mem_we_o}, 32'h0);
    check_eq("reset addr", bus.mem_addr_o, 32'h0);
    check_eq("reset wdata", bus.mem_wdata_o, 32'h0);
    rst = 1'b0;

    // Cold load of 0x40: four read beats, then a hit on cycle 6.
    clear_log();
    access(1'b0, 32'h40, 32'h0, cyc);
    check_eq("cold cycles", cyc, 6);
    check_eq("cold rdata", bus.rdata_o, 32'h11);
    check_eq("cold beats", log_addr.size(), 4);
    check_beats("cold", 0, 1'b0, 32'h40);
    clear_log();
    access(1'b0, 32'h48, 32'h0, cyc);
    check_eq("hit48 cycles", cyc, 1);
    check_eq("hit48 rdata", bus.rdata_o, 32'h33);

    // Store hit to 0x44, then load it back.
    access(1'b1, 32'h44, 32'hDEAD_BEEF, cyc);
    check_eq("store cycles", cyc, 1);
    check_eq("store req", {31'h0, bus.mem_req_o}, 32'h0);
    access(1'b0, 32'h44, 32'h0, cyc);
    check_eq("load44 cycles", cyc, 1);
    check_eq("load44 rdata", bus.rdata_o, 32'hDEAD_BEEF);
    check_eq("hit no beats", log_addr.size(), 0);

    // Dirty eviction: load 0x440 writes back line 4 first.
    clear_log();
    access(1'b0, 32'h440, 32'h0, cyc);
    check_eq("evict cycles", cyc, 10);
    check_eq("evict rdata", bus.rdata_o, 32'h55);
    check_eq("evict beats", log_addr.size(), 8);
    check_beats("wb", 0, 1'b1, 32'h40);
    check_beats("refill", 4, 1'b0, 32'h440);
    if (log_data.size() >= 4) begin
      check_eq("wb d0", log_data[0], 32'h11);
      check_eq("wb d1", log_data[1], 32'hDEAD_BEEF);
      check_eq("wb d2", log_data[2], 32'h33);
      check_eq("wb d3", log_data[3], 32'h44);
    end else begin
      check_eq("wb data count", log_data.size(), 4);
    end
    check_eq("mem 0x44", mem_model[17], 32'hDEAD_BEEF);

    // Backpressure: ready only every third cycle during the fill of 0x80.
    clear_log();
    ready_mode = 1'b1;
    stab_err = 0;
    access(1'b0, 32'h80, 32'h0, cyc);
    check_eq("bp hit", {31'h0, bus.hit_o}, 32'h1);
    check_eq("bp hit timing", pc, last_beat_pc);
    check_eq("bp addr stable", stab_err, 0);
    check_eq("bp rdata", bus.rdata_o, 32'hA0);
    check_beats("bp", 0, 1'b0, 32'h80);
    ready_mode = 1'b0;
    access(1'b0, 32'h8C, 32'h0, cyc);
    check_eq("bp word3 cycles", cyc, 1);
    check_eq("bp word3", bus.rdata_o, 32'hA3);

    // Reset during beat 2 of a fill of 0xC0.
    clear_log();
    @(negedge clk);
    bus.en_i   = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 32'hC0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("pre-rst addr", bus.mem_addr_o, 32'hC8);
    check_eq("pre-rst beats", log_addr.size(), 2);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst req drop", {31'h0, bus.mem_req_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.en_i = 1'b0;
    clear_log();
    access(1'b0, 32'hC0, 32'h0, cyc);
    check_eq("post-rst cycles", cyc, 6);
    check_eq("post-rst beats", log_addr.size(), 4);
    check_beats("post-rst", 0, 1'b0, 32'hC0);
    check_eq("post-rst rdata", bus.rdata_o, 32'h99);

    // Idle: en_i low with an arbitrary address.
    clear_log();
    @(negedge clk);
    bus.en_i   = 1'b0;
    bus.addr_i = 32'h1234_5670;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("idle hit", {31'h0, bus.hit_o}, 32'h1);
      check_eq("idle req", {31'h0, bus.mem_req_o}, 32'h0);
      @(negedge clk);
    end
    access(1'b0, 32'hC4, 32'h0, cyc);
    check_eq("after idle cycles", cyc, 1);
    check_eq("after idle rdata", bus.rdata_o, 32'h9A);
    check_eq("idle beats", log_addr.size(), 0);

    @(negedge clk);
    bus.en_i = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
